// File: rtl/sys_mgr_sync_barrier_if.sv
// ============================================================================
// Module   : sys_mgr_sync_barrier_if
// Purpose  : Manager/system barrier handshake bundle for sys_mgr_sync_barrier.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MGR_ARRAY_NUM_OF_MGR
`define MGR_ARRAY_NUM_OF_MGR 4
`endif

interface sys_mgr_sync_barrier_if #(
  parameter int NUM_MGR   = `MGR_ARRAY_NUM_OF_MGR,
  parameter int TIMEOUT_W = 16
);
  logic [NUM_MGR-1:0]   mgr__sys__allSynchronized;
  logic [NUM_MGR-1:0]   cfg__sync__enableMask;
  logic [TIMEOUT_W-1:0] cfg__sync__timeout;
  logic                 sys__sync__clearErr;
  logic [NUM_MGR-1:0]   sys__mgr__thisSynchronized;
  logic                 sys__mgr__ready;
  logic                 sys__mgr__complete;
  logic                 sync__sys__timeoutErr;
  logic [NUM_MGR-1:0]   sync__sys__missingMask;
  logic [15:0]          sync__sys__barrierCount;

  modport master (
    output mgr__sys__allSynchronized, cfg__sync__enableMask,
           cfg__sync__timeout, sys__sync__clearErr,
    input  sys__mgr__thisSynchronized, sys__mgr__ready, sys__mgr__complete,
           sync__sys__timeoutErr, sync__sys__missingMask, sync__sys__barrierCount
  );

  modport slave (
    input  mgr__sys__allSynchronized, cfg__sync__enableMask,
           cfg__sync__timeout, sys__sync__clearErr,
    output sys__mgr__thisSynchronized, sys__mgr__ready, sys__mgr__complete,
           sync__sys__timeoutErr, sync__sys__missingMask, sync__sys__barrierCount
  );
endinterface

`default_nettype wire

// File: rtl/sys_mgr_sync_barrier.sv
// ============================================================================
// Module   : sys_mgr_sync_barrier
// Purpose  : Gathers manager barrier requests, releases them together, counts
//            completed barriers and flags managers missing at timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef MGR_ARRAY_NUM_OF_MGR
`define MGR_ARRAY_NUM_OF_MGR 4
`endif

module sys_mgr_sync_barrier #(
  parameter int NUM_MGR     = `MGR_ARRAY_NUM_OF_MGR,
  parameter int INIT_CYCLES = 8,
  parameter int TIMEOUT_W   = 16
) (
  input  wire logic             clk,
  input  wire logic             reset_poweron,
  sys_mgr_sync_barrier_if.slave bus
);

  localparam int INIT_W = (INIT_CYCLES < 1) ? 1 : $clog2(INIT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_IDLE    = 3'd1,
    S_GATHER  = 3'd2,
    S_RELEASE = 3'd3,
    S_ERROR   = 3'd4
  } state_t;

  state_t               r_state;
  logic [INIT_W-1:0]    r_init_cnt;
  logic [TIMEOUT_W-1:0] r_tmo_cnt;
  logic [NUM_MGR-1:0]   r_act_mask;
  logic [NUM_MGR-1:0]   r_arrived;
  logic [NUM_MGR-1:0]   r_this_sync;
  logic [NUM_MGR-1:0]   r_missing;
  logic                 r_ready;
  logic                 r_complete;
  logic                 r_timeout_err;
  logic [15:0]          r_barrier_count;

  logic [NUM_MGR-1:0]   w_req_en;
  logic [NUM_MGR-1:0]   w_req_act;
  logic [NUM_MGR-1:0]   w_keep;
  logic                 w_all_in;
  logic                 w_tmo_hit;

  assign w_req_en  = bus.mgr__sys__allSynchronized & bus.cfg__sync__enableMask;
  assign w_req_act = bus.mgr__sys__allSynchronized & r_act_mask;
  // Released managers only ever drop out; a re-raised request waits for IDLE.
  assign w_keep    = r_arrived & bus.mgr__sys__allSynchronized;
  assign w_all_in  = &(r_arrived | ~r_act_mask);
  assign w_tmo_hit = (bus.cfg__sync__timeout != '0) &&
                     (r_tmo_cnt == (bus.cfg__sync__timeout - TIMEOUT_W'(1)));

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      r_state         <= S_INIT;
      r_init_cnt      <= '0;
      r_tmo_cnt       <= '0;
      r_act_mask      <= '0;
      r_arrived       <= '0;
      r_this_sync     <= '0;
      r_missing       <= '0;
      r_ready         <= 1'b0;
      r_complete      <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_barrier_count <= '0;
    end else begin
      r_complete <= 1'b0;
      case (r_state)
        S_INIT: begin
          if (r_init_cnt == INIT_W'(INIT_CYCLES)) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_init_cnt <= r_init_cnt + INIT_W'(1);
          end
        end
        S_IDLE: begin
          if (|w_req_en) begin
            r_state    <= S_GATHER;
            r_act_mask <= bus.cfg__sync__enableMask;
            r_arrived  <= w_req_en;
            r_tmo_cnt  <= '0;
          end
        end
        S_GATHER: begin
          r_arrived <= r_arrived | w_req_act;
          // Completion is checked first so a last-cycle arrival beats the timeout.
          if (w_all_in) begin
            r_state     <= S_RELEASE;
            r_this_sync <= r_arrived;
            r_tmo_cnt   <= '0;
          end else if (w_tmo_hit) begin
            r_state       <= S_ERROR;
            r_missing     <= r_act_mask & ~r_arrived;
            r_timeout_err <= 1'b1;
            r_this_sync   <= '0;
            r_tmo_cnt     <= '0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TIMEOUT_W'(1);
          end
        end
        S_RELEASE: begin
          r_arrived   <= w_keep;
          r_this_sync <= w_keep;
          if (w_keep == '0) begin
            r_state         <= S_IDLE;
            r_complete      <= 1'b1;
            r_barrier_count <= r_barrier_count + 16'd1;
          end
        end
        S_ERROR: begin
          if (bus.sys__sync__clearErr) begin
            r_state       <= S_IDLE;
            r_arrived     <= '0;
            r_timeout_err <= 1'b0;
            r_missing     <= '0;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign bus.sys__mgr__thisSynchronized = r_this_sync;
  assign bus.sys__mgr__ready            = r_ready;
  assign bus.sys__mgr__complete         = r_complete;
  assign bus.sync__sys__timeoutErr      = r_timeout_err;
  assign bus.sync__sys__missingMask     = r_missing;
  assign bus.sync__sys__barrierCount    = r_barrier_count;

endmodule

`default_nettype wire

// File: tb/tb_sys_mgr_sync_barrier.sv
// ============================================================================
// Module   : tb_sys_mgr_sync_barrier
// Purpose  : Self-checking bench with a release/completion scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sys_mgr_sync_barrier;
  localparam int NM = 4;
  localparam int IC = 8;
  localparam int TW = 16;

  logic clk = 1'b0;
  logic reset_poweron;
  int   n_total = 0;
  int   n_bad   = 0;

  typedef struct {
    logic [NM-1:0] rel;
    logic [15:0]   cnt;
  } exp_t;
  exp_t        exp_q[$];
  logic [15:0] exp_cnt;
  logic [NM-1:0] prev_ts;

  always #5 clk = ~clk;

  sys_mgr_sync_barrier_if #(.NUM_MGR(NM), .TIMEOUT_W(TW)) bus ();

  sys_mgr_sync_barrier #(
    .NUM_MGR(NM), .INIT_CYCLES(IC), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk),
    .reset_poweron(reset_poweron),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [NM-1:0] rel);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.rel = rel;
    e.cnt = exp_cnt;
    exp_q.push_back(e);
  endtask

  // Scoreboard: release mask on each rising edge of thisSynchronized, count on complete.
  always @(negedge clk) begin
    exp_t e;
    if (reset_poweron) begin
      prev_ts = '0;
    end else begin
      if (bus.sys__mgr__thisSynchronized != '0 && prev_ts == '0) begin
        if (exp_q.size() == 0) chk("sb_release_unexpected", exp_q.size(), 1);
        else chk("sb_release", bus.sys__mgr__thisSynchronized, exp_q[0].rel);
      end
      if (bus.sys__mgr__complete) begin
        if (exp_q.size() == 0) chk("sb_complete_unexpected", exp_q.size(), 1);
        else begin
          e = exp_q.pop_front();
          chk("sb_count", bus.sync__sys__barrierCount, e.cnt);
        end
      end
      prev_ts = bus.sys__mgr__thisSynchronized;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    exp_cnt = '0;
    reset_poweron = 1'b1;
    bus.mgr__sys__allSynchronized = '0;
    bus.cfg__sync__enableMask     = '0;
    bus.cfg__sync__timeout        = '0;
    bus.sys__sync__clearErr       = 1'b0;
    tick(2);
    chk("rst_ready",    bus.sys__mgr__ready, 0);
    chk("rst_ts",       bus.sys__mgr__thisSynchronized, 0);
    chk("rst_complete", bus.sys__mgr__complete, 0);
    chk("rst_err",      bus.sync__sys__timeoutErr, 0);
    chk("rst_missing",  bus.sync__sys__missingMask, 0);
    chk("rst_count",    bus.sync__sys__barrierCount, 0);
    reset_poweron = 1'b0;
    tick(IC);
    chk("ready_before", bus.sys__mgr__ready, 0);
    tick(1);
    chk("ready_after", bus.sys__mgr__ready, 1);

    // Full barrier with staggered arrivals.
    bus.cfg__sync__enableMask = 4'hF;
    push_exp(4'hF);
    bus.mgr__sys__allSynchronized = 4'h1; tick(2);
    bus.mgr__sys__allSynchronized = 4'h3; tick(3);
    bus.mgr__sys__allSynchronized = 4'h7; tick(3);
    chk("full_wait_ts", bus.sys__mgr__thisSynchronized, 0);
    tick(2);
    bus.mgr__sys__allSynchronized = 4'hF; tick(1);
    chk("full_lat1_ts", bus.sys__mgr__thisSynchronized, 0);
    tick(1);
    chk("full_ts", bus.sys__mgr__thisSynchronized, 4'hF);
    tick(3);
    bus.mgr__sys__allSynchronized = 4'h0; tick(1);
    chk("full_complete", bus.sys__mgr__complete, 1);
    chk("full_count", bus.sync__sys__barrierCount, 1);
    chk("full_drop_ts", bus.sys__mgr__thisSynchronized, 0);
    tick(1);
    chk("full_complete_pulse", bus.sys__mgr__complete, 0);

    // Partial mask: mgr1 is not enabled, mask widening mid-barrier is deferred.
    bus.cfg__sync__enableMask = 4'h5;
    bus.mgr__sys__allSynchronized = 4'h2; tick(3);
    chk("part_ignored_ts", bus.sys__mgr__thisSynchronized, 0);
    push_exp(4'h5);
    bus.mgr__sys__allSynchronized = 4'h3; tick(1);
    bus.cfg__sync__enableMask = 4'hF;
    bus.mgr__sys__allSynchronized = 4'h1; tick(1);
    bus.mgr__sys__allSynchronized = 4'h3; tick(2);
    chk("part_wait_ts", bus.sys__mgr__thisSynchronized, 0);
    bus.mgr__sys__allSynchronized = 4'h7; tick(2);
    chk("part_ts", bus.sys__mgr__thisSynchronized, 4'h5);
    bus.mgr__sys__allSynchronized = 4'h0; tick(1);
    chk("part_count", bus.sync__sys__barrierCount, 2);
    tick(1);

    // Timeout with mgr1/mgr2 missing.
    bus.cfg__sync__enableMask = 4'hF;
    bus.cfg__sync__timeout = 16'd20;
    bus.mgr__sys__allSynchronized = 4'h9; tick(20);
    chk("tmo_err_early", bus.sync__sys__timeoutErr, 0);
    tick(1);
    chk("tmo_err", bus.sync__sys__timeoutErr, 1);
    chk("tmo_missing", bus.sync__sys__missingMask, 4'h6);
    chk("tmo_ts", bus.sys__mgr__thisSynchronized, 0);
    bus.mgr__sys__allSynchronized = 4'hF; tick(3);
    chk("tmo_ignored_ts", bus.sys__mgr__thisSynchronized, 0);
    chk("tmo_sticky", bus.sync__sys__timeoutErr, 1);
    bus.mgr__sys__allSynchronized = 4'h0;
    bus.sys__sync__clearErr = 1'b1; tick(1);
    bus.sys__sync__clearErr = 1'b0;
    chk("clr_err", bus.sync__sys__timeoutErr, 0);
    chk("clr_missing", bus.sync__sys__missingMask, 0);
    push_exp(4'hF);
    bus.mgr__sys__allSynchronized = 4'hF; tick(2);
    chk("post_err_ts", bus.sys__mgr__thisSynchronized, 4'hF);
    bus.mgr__sys__allSynchronized = 4'h0; tick(1);
    chk("post_err_count", bus.sync__sys__barrierCount, 3);
    tick(1);

    // Last arrival coincides with the timeout compare: release wins.
    bus.cfg__sync__enableMask = 4'h3;
    bus.cfg__sync__timeout = 16'd6;
    push_exp(4'h3);
    bus.mgr__sys__allSynchronized = 4'h1; tick(5);
    bus.mgr__sys__allSynchronized = 4'h3; tick(2);
    chk("race_ts", bus.sys__mgr__thisSynchronized, 4'h3);
    chk("race_err", bus.sync__sys__timeoutErr, 0);
    bus.mgr__sys__allSynchronized = 4'h0; tick(1);
    chk("race_count", bus.sync__sys__barrierCount, 4);
    tick(1);

    // Re-raise during RELEASE is deferred to the next IDLE.
    bus.cfg__sync__timeout = 16'd0;
    push_exp(4'h3);
    bus.mgr__sys__allSynchronized = 4'h3; tick(2);
    chk("rr_ts", bus.sys__mgr__thisSynchronized, 4'h3);
    bus.mgr__sys__allSynchronized = 4'h2; tick(1);
    chk("rr_drop_ts", bus.sys__mgr__thisSynchronized, 4'h2);
    bus.mgr__sys__allSynchronized = 4'h3; tick(1);
    chk("rr_noarm_ts", bus.sys__mgr__thisSynchronized, 4'h2);
    bus.mgr__sys__allSynchronized = 4'h1; tick(1);
    chk("rr_complete", bus.sys__mgr__complete, 1);
    chk("rr_count", bus.sync__sys__barrierCount, 5);
    push_exp(4'h3);
    bus.mgr__sys__allSynchronized = 4'h3; tick(2);
    chk("b2b_ts", bus.sys__mgr__thisSynchronized, 4'h3);
    bus.mgr__sys__allSynchronized = 4'h0; tick(1);
    chk("b2b_count", bus.sync__sys__barrierCount, 6);
    tick(1);

    // All-zero enable mask never starts a barrier.
    bus.cfg__sync__enableMask = 4'h0;
    bus.mgr__sys__allSynchronized = 4'hF; tick(4);
    chk("zmask_ts", bus.sys__mgr__thisSynchronized, 0);
    chk("zmask_count", bus.sync__sys__barrierCount, 6);
    bus.mgr__sys__allSynchronized = 4'h0; tick(1);

    // Asynchronous reset in the middle of GATHER.
    bus.cfg__sync__enableMask = 4'hF;
    bus.mgr__sys__allSynchronized = 4'h1; tick(2);
    reset_poweron = 1'b1;
    #1;
    chk("mid_rst_ready", bus.sys__mgr__ready, 0);
    chk("mid_rst_count", bus.sync__sys__barrierCount, 0);
    bus.mgr__sys__allSynchronized = 4'h0;
    exp_cnt = '0;
    tick(1);
    reset_poweron = 1'b0;
    tick(IC);
    chk("mid_rst_ready_before", bus.sys__mgr__ready, 0);
    tick(1);
    chk("mid_rst_ready_after", bus.sys__mgr__ready, 1);

    // Counter wrap from 0xFFFF.
    force dut.r_barrier_count = 16'hFFFF;
    tick(1);
    release dut.r_barrier_count;
    tick(1);
    chk("wrap_preload", bus.sync__sys__barrierCount, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    push_exp(4'hF);
    bus.mgr__sys__allSynchronized = 4'hF; tick(2);
    chk("wrap_ts", bus.sys__mgr__thisSynchronized, 4'hF);
    bus.mgr__sys__allSynchronized = 4'h0; tick(1);
    chk("wrap_count", bus.sync__sys__barrierCount, 0);
    tick(2);

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
